// File: rtl/ct_biu_lpmd_ctrl.sv
// BIU low-power controller: drains outstanding AXI reads/writes on CP0 request,
// reports quiescence, and runs the req/ack low-power handshake with the SoC.
module ct_biu_lpmd_ctrl #(
    parameter int CNT_W      = 5,
    parameter int MAX_OUTSTD = 16
) (
    input  logic       forever_cpuclk,
    input  logic       cpurst,
    input  logic       cp0_biu_no_op_req,
    input  logic [1:0] cp0_biu_lpmd_b,
    input  logic       biu_ar_hs,
    input  logic       biu_r_last_hs,
    input  logic       biu_aw_hs,
    input  logic       biu_b_hs,
    input  logic       pad_biu_lpmd_ack,
    output logic       biu_yy_xx_no_op,
    output logic       biu_req_block,
    output logic       biu_rd_full,
    output logic       biu_wr_full,
    output logic       biu_pad_lpmd_req,
    output logic [1:0] biu_pad_lpmd_b,
    output logic       biu_lpmd_err
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTD);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        QUIET = 3'd2,
        LPREQ = 3'd3,
        LPMD  = 3'd4,
        EXIT  = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             err_q, err_d;
    logic             hs_any;

    assign hs_any = biu_ar_hs | biu_r_last_hs | biu_aw_hs | biu_b_hs;

    // Outputs decode only registered state, so no input reaches them combinationally.
    assign biu_yy_xx_no_op  = (state_q == QUIET) || (state_q == LPREQ) ||
                              (state_q == LPMD)  || (state_q == EXIT);
    assign biu_req_block    = (state_q != IDLE);
    assign biu_pad_lpmd_req = (state_q == LPREQ) || (state_q == LPMD);
    assign biu_pad_lpmd_b   = mode_q;
    assign biu_lpmd_err     = err_q;
    assign biu_rd_full      = (rd_cnt_q == MAX_C);
    assign biu_wr_full      = (wr_cnt_q == MAX_C);

    // Outstanding counters: simultaneous inc/dec cancel; saturate and flag on misuse.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        err_d    = err_q;
        if (biu_ar_hs && !biu_r_last_hs) begin
            if (rd_cnt_q == MAX_C) err_d = 1'b1;
            else                   rd_cnt_d = rd_cnt_q + ONE_C;
        end else if (biu_r_last_hs && !biu_ar_hs) begin
            if (rd_cnt_q == '0) err_d = 1'b1;
            else                rd_cnt_d = rd_cnt_q - ONE_C;
        end
        if (biu_aw_hs && !biu_b_hs) begin
            if (wr_cnt_q == MAX_C) err_d = 1'b1;
            else                   wr_cnt_d = wr_cnt_q + ONE_C;
        end else if (biu_b_hs && !biu_aw_hs) begin
            if (wr_cnt_q == '0) err_d = 1'b1;
            else                wr_cnt_d = wr_cnt_q - ONE_C;
        end
        // Bus traffic once quiescence was reported means the issue side ignored block.
        if (hs_any && biu_yy_xx_no_op) err_d = 1'b1;
    end

    // Low-power sequencing: next state and latched SoC mode.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE:  if (cp0_biu_no_op_req) state_d = DRAIN;
            DRAIN: begin
                if (!cp0_biu_no_op_req)
                    state_d = IDLE;
                else if (rd_cnt_q == '0 && wr_cnt_q == '0 && !hs_any)
                    state_d = QUIET;
            end
            QUIET: begin
                if (cp0_biu_lpmd_b != 2'b11) begin
                    state_d = LPREQ;
                    mode_d  = cp0_biu_lpmd_b;
                end else if (!cp0_biu_no_op_req) begin
                    state_d = IDLE;
                end
            end
            // Wake-up here is deferred until the SoC has acknowledged.
            LPREQ: if (pad_biu_lpmd_ack) state_d = LPMD;
            LPMD: begin
                if (cp0_biu_lpmd_b == 2'b11) begin
                    state_d = EXIT;
                    mode_d  = 2'b11;
                end
            end
            EXIT:  if (!pad_biu_lpmd_ack) state_d = IDLE;
            default: begin
                state_d = IDLE;
                mode_d  = 2'b11;
            end
        endcase
    end

    // State, counters, mode and sticky error registers.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q  <= IDLE;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            mode_q   <= 2'b11;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_ct_biu_lpmd_ctrl.sv
// Self-checking bench for ct_biu_lpmd_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model.
module tb_ct_biu_lpmd_ctrl;

    localparam int MAXO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       no_op_req;
    logic [1:0] lpmd_b;
    logic       ar, rl, aw, b, ack;
    logic       no_op, block, rd_full, wr_full, req, err;
    logic [1:0] pad_b;

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural model
    localparam int P_IDLE = 0, P_DRAIN = 1, P_QUIET = 2, P_LPREQ = 3, P_LPMD = 4, P_EXIT = 5;
    int       m_ph, m_rd, m_wr;
    bit       m_err;
    bit [1:0] m_mode;

    ct_biu_lpmd_ctrl #(.CNT_W(5), .MAX_OUTSTD(MAXO)) dut (
        .forever_cpuclk    (clk),
        .cpurst            (rst),
        .cp0_biu_no_op_req (no_op_req),
        .cp0_biu_lpmd_b    (lpmd_b),
        .biu_ar_hs         (ar),
        .biu_r_last_hs     (rl),
        .biu_aw_hs         (aw),
        .biu_b_hs          (b),
        .pad_biu_lpmd_ack  (ack),
        .biu_yy_xx_no_op   (no_op),
        .biu_req_block     (block),
        .biu_rd_full       (rd_full),
        .biu_wr_full       (wr_full),
        .biu_pad_lpmd_req  (req),
        .biu_pad_lpmd_b    (pad_b),
        .biu_lpmd_err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_rd = 0; m_wr = 0; m_err = 0; m_mode = 2'b11;
    endtask

    // one clock of the reference behaviour, using the inputs presented this cycle
    task automatic model_clk();
        bit quiet = (m_ph >= P_QUIET);
        bit hs    = ar | rl | aw | b;
        int nph   = m_ph;
        if (quiet && hs) m_err = 1;
        if (nph == P_DRAIN && !no_op_req) nph = P_IDLE;
        else case (m_ph)
            P_IDLE:  if (no_op_req) nph = P_DRAIN;
            P_DRAIN: if (m_rd == 0 && m_wr == 0 && !hs) nph = P_QUIET;
            P_QUIET: if (lpmd_b != 2'b11) begin nph = P_LPREQ; m_mode = lpmd_b; end
                     else if (!no_op_req) nph = P_IDLE;
            P_LPREQ: if (ack) nph = P_LPMD;
            P_LPMD:  if (lpmd_b == 2'b11) begin nph = P_EXIT; m_mode = 2'b11; end
            P_EXIT:  if (!ack) nph = P_IDLE;
            default: nph = P_IDLE;
        endcase
        m_ph = nph;
        if (ar != rl) begin
            if (ar) begin if (m_rd == MAXO) m_err = 1; else m_rd++; end
            else    begin if (m_rd == 0)    m_err = 1; else m_rd--; end
        end
        if (aw != b) begin
            if (aw) begin if (m_wr == MAXO) m_err = 1; else m_wr++; end
            else    begin if (m_wr == 0)    m_err = 1; else m_wr--; end
        end
    endtask

    task automatic check_all();
        chk("no_op",   32'(no_op),   32'(m_ph >= P_QUIET));
        chk("block",   32'(block),   32'(m_ph != P_IDLE));
        chk("req",     32'(req),     32'(m_ph == P_LPREQ || m_ph == P_LPMD));
        chk("pad_b",   32'(pad_b),   32'(m_mode));
        chk("rd_full", 32'(rd_full), 32'(m_rd == MAXO));
        chk("wr_full", 32'(wr_full), 32'(m_wr == MAXO));
        chk("err",     32'(err),     32'(m_err));
    endtask

    task automatic step(input bit nr, input bit [1:0] lb, input bit i_ar, input bit i_rl,
                        input bit i_aw, input bit i_b, input bit i_ack);
        no_op_req = nr; lpmd_b = lb; ar = i_ar; rl = i_rl; aw = i_aw; b = i_b; ack = i_ack;
        @(posedge clk);
        model_clk();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1; no_op_req = 0; lpmd_b = 2'b11; ar = 0; rl = 0; aw = 0; b = 0; ack = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        check_all();
    endtask

    initial begin
        do_reset();
        chk("rst_pad_b", 32'(pad_b), 32'h3);

        // idle drain
        step(1, 2'b11, 0, 0, 0, 0, 0);
        chk("drain_block", 32'(block), 1);
        chk("drain_noop",  32'(no_op), 0);
        step(1, 2'b11, 0, 0, 0, 0, 0);
        chk("quiet_noop",  32'(no_op), 1);

        // outstanding drain
        do_reset();
        repeat (3) step(0, 2'b11, 1, 0, 0, 0, 0);
        step(1, 2'b11, 1, 1, 0, 0, 0);
        step(1, 2'b11, 0, 1, 0, 0, 0);
        step(1, 2'b11, 0, 1, 0, 0, 0);
        chk("out_noop_pre", 32'(no_op), 0);
        step(1, 2'b11, 0, 1, 0, 0, 0);
        chk("out_noop_last", 32'(no_op), 0);
        step(1, 2'b11, 0, 0, 0, 0, 0);
        chk("out_noop_rise", 32'(no_op), 1);

        // full entry / exit
        step(1, 2'b00, 0, 0, 0, 0, 0);
        chk("entry_req", 32'(req), 1);
        chk("entry_mode", 32'(pad_b), 0);
        step(1, 2'b00, 0, 0, 0, 0, 1);
        step(1, 2'b11, 0, 0, 0, 0, 1);
        chk("exit_req", 32'(req), 0);
        chk("exit_mode", 32'(pad_b), 3);
        step(1, 2'b11, 0, 0, 0, 0, 0);
        chk("exit_idle_noop", 32'(no_op), 0);

        // early wake
        do_reset();
        step(1, 2'b11, 0, 0, 0, 0, 0);
        step(1, 2'b11, 0, 0, 0, 0, 0);
        step(1, 2'b01, 0, 0, 0, 0, 0);
        step(1, 2'b11, 0, 0, 0, 0, 0);
        chk("wake_hold_req", 32'(req), 1);
        step(1, 2'b11, 0, 0, 0, 0, 1);
        step(1, 2'b11, 0, 0, 0, 0, 1);
        chk("wake_exit_req", 32'(req), 0);
        step(1, 2'b11, 0, 0, 0, 0, 0);
        chk("wake_idle_block", 32'(block), 0);

        // limits
        do_reset();
        repeat (MAXO) step(0, 2'b11, 0, 0, 1, 0, 0);
        chk("wr_full16", 32'(wr_full), 1);
        chk("no_err16", 32'(err), 0);
        step(0, 2'b11, 0, 0, 1, 0, 0);
        chk("ovf_err", 32'(err), 1);
        chk("ovf_full", 32'(wr_full), 1);
        do_reset();
        step(0, 2'b11, 0, 0, 0, 1, 0);
        chk("unf_err", 32'(err), 1);

        // async reset while in LPMD
        do_reset();
        step(1, 2'b11, 0, 0, 0, 0, 0);
        step(1, 2'b11, 0, 0, 0, 0, 0);
        step(1, 2'b10, 0, 0, 0, 0, 0);
        step(1, 2'b10, 0, 0, 0, 0, 1);
        chk("lpmd_req", 32'(req), 1);
        #2 rst = 1;
        #1;
        chk("arst_req", 32'(req), 0);
        chk("arst_pad_b", 32'(pad_b), 3);
        chk("arst_noop", 32'(no_op), 0);
        chk("arst_block", 32'(block), 0);
        do_reset();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 399) do_reset();
            else step(($urandom % 8) != 0,
                      (($urandom % 4) == 0) ? 2'($urandom) : 2'b11,
                      ($urandom % 10) == 0, ($urandom % 10) == 0,
                      ($urandom % 10) == 0, ($urandom % 10) == 0,
                      ($urandom % 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ct_biu_lpmd_ctrl.md
Name: ct_biu_lpmd_ctrl

Overview:
BIU-side low-power controller. It drains outstanding AXI read/write transactions when CP0 requests quiescence, then returns biu_yy_xx_no_op to the CP0 low-power FSM. Once CP0 drives a low-power mode on cp0_biu_lpmd_b, it runs a four-phase req/ack handshake with the SoC power controller, and tears that handshake down on wake-up. It sits directly downstream of the CP0 low-power-mode logic and upstream of the pad/sysio interface.

Parameters:
CNT_W, 5, width of each outstanding-transaction counter
MAX_OUTSTD, 16, outstanding limit per channel; must satisfy MAX_OUTSTD < 2^CNT_W

Ports:
forever_cpuclk  in  1  ungated core clock
cpurst  in  1  asynchronous active-high reset
cp0_biu_no_op_req  in  1  CP0 requests BIU quiescence (level)
cp0_biu_lpmd_b  in  2  low-power mode from CP0, active-low; 2'b11 = run
biu_ar_hs  in  1  AR valid&ready handshake this cycle
biu_r_last_hs  in  1  R valid&ready&last this cycle
biu_aw_hs  in  1  AW valid&ready handshake this cycle
biu_b_hs  in  1  B valid&ready this cycle
pad_biu_lpmd_ack  in  1  SoC acknowledge of low-power request
biu_yy_xx_no_op  out  1  BIU quiescent, no outstanding transactions
biu_req_block  out  1  block new AR/AW issue
biu_rd_full  out  1  read counter == MAX_OUTSTD
biu_wr_full  out  1  write counter == MAX_OUTSTD
biu_pad_lpmd_req  out  1  low-power request to SoC
biu_pad_lpmd_b  out  2  latched mode sent to SoC
biu_lpmd_err  out  1  sticky protocol error (counter underflow/overflow)

Behaviour:
- Reset (async, cpurst=1):
  - state=IDLE, both counters 0
  - all 1-bit outputs 0
  - biu_pad_lpmd_b=2'b11
- Counters (rd_cnt, wr_cnt, CNT_W bits):
  - rd_cnt +1 on biu_ar_hs, -1 on biu_r_last_hs; both in the same cycle -> unchanged. wr_cnt likewise with biu_aw_hs/biu_b_hs.
  - Decrement alone at 0 -> hold 0, set biu_lpmd_err.
  - Increment alone at MAX_OUTSTD -> hold, set biu_lpmd_err.
  - biu_rd_full/biu_wr_full are combinational compares.
- FSM, registered on forever_cpuclk:
  - IDLE: no_op=0, block=0. If cp0_biu_no_op_req -> DRAIN.
  - DRAIN: block=1. If !cp0_biu_no_op_req -> IDLE (priority). Else if rd_cnt==0, wr_cnt==0 and no handshake input active this cycle -> QUIET.
  - QUIET: block=1, no_op=1.
    - If cp0_biu_lpmd_b!=2'b11 -> LPREQ, and latch cp0_biu_lpmd_b into biu_pad_lpmd_b.
    - Else if !cp0_biu_no_op_req -> IDLE.
  - LPREQ: block=1, no_op=1, req=1. On pad_biu_lpmd_ack -> LPMD. A wake-up (lpmd_b==11) seen here does not abort; the handshake completes first.
  - LPMD: block=1, no_op=1, req=1. If cp0_biu_lpmd_b==2'b11 -> EXIT.
  - EXIT: block=1, no_op=1, req=0, biu_pad_lpmd_b returns to 2'b11. When pad_biu_lpmd_ack==0 -> IDLE.
- Outputs:
  - biu_yy_xx_no_op, biu_req_block and biu_pad_lpmd_req are registered state decodes, with no combinational path from any input.
  - No-op latency: 1 cycle after the counters reach 0 (DRAIN->QUIET).
- Handshake inputs arriving in QUIET or later are protocol errors: set biu_lpmd_err; counters still update.
- cp0_biu_lpmd_b!=2'b11 in IDLE or DRAIN is ignored; mode entry is taken only from QUIET.
- Reset mid-handshake: immediate return to reset values; the SoC side tolerates req dropping.

Test Plan:
- Idle drain: cnt 0, assert cp0_biu_no_op_req -> DRAIN at cycle 1, QUIET and no_op=1 at cycle 2, block=1 from cycle 1.
- Outstanding drain: 3 AR handshakes, then no_op_req. no_op must stay 0 until the 3rd r_last; it rises exactly 1 cycle after. A simultaneous AR+r_last leaves the count unchanged.
- Full entry/exit: from QUIET drive lpmd_b=2'b00 -> req=1, biu_pad_lpmd_b=00. ack=1 -> LPMD. lpmd_b=11 -> EXIT, req=0, biu_pad_lpmd_b=11. ack=0 -> IDLE with no_op=0.
- Early wake: lpmd_b returns to 11 while in LPREQ before ack. FSM waits for ack, goes LPMD for 1 cycle, then EXIT, then IDLE when ack drops.
- Limits: 16 AW handshakes -> biu_wr_full=1. A 17th -> count holds at 16, err=1. A B handshake at count 0 -> err=1 and the count stays 0.
- Async reset in LPMD: assert cpurst mid-cycle -> req=0, biu_pad_lpmd_b=11 and state IDLE immediately, without waiting for a clock edge.
